// File: rtl/if_id_decode_pkg.sv
// if_id_decode_pkg: shared widths, field positions and helpers for the IF/ID decode stage
package if_id_decode_pkg;
   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 2 ** REG_ADDR_W;
   localparam int OPCODE_W   = 6;
   localparam int FUNCT_W    = 6;
   localparam int OPCODE_LSB = 26;
   localparam int RS_LSB     = 21;
   localparam int RT_LSB     = 16;
   localparam int RD_LSB     = 11;
   localparam logic [DATA_W-1:0]     NOP_INSTR = '0;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO  = '0;

   function automatic logic [DATA_W-1:0] sign_ext16(input logic [15:0] imm);
      return {{(DATA_W-16){imm[15]}}, imm};
   endfunction
endpackage

// File: rtl/if_id_decode_register_file.sv
// register_file: 32x32 register file, 2 combinational reads, 1 sync write, $zero, write-through
//  clk, rst (async active-low clear); i_we/i_wa/i_wd write port; i_ra1/i_ra2 -> o_rd1/o_rd2
module register_file
   import if_id_decode_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_we,
   input  logic [REG_ADDR_W-1:0] i_wa,
   input  logic [DATA_W-1:0]     i_wd,
   input  logic [REG_ADDR_W-1:0] i_ra1,
   input  logic [REG_ADDR_W-1:0] i_ra2,
   output logic [DATA_W-1:0]     o_rd1,
   output logic [DATA_W-1:0]     o_rd2
);
   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic              wr_hit;

   assign wr_hit = i_we && (i_wa != REG_ZERO);

   always_comb begin
      regs_d = regs_q;
      if (wr_hit) regs_d[i_wa] = i_wd;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   // Same-cycle WB write is forwarded so ID sees the value being written this cycle
   assign o_rd1 = (i_ra1 == REG_ZERO) ? '0 : (wr_hit && i_wa == i_ra1) ? i_wd : regs_q[i_ra1];
   assign o_rd2 = (i_ra2 == REG_ZERO) ? '0 : (wr_hit && i_wa == i_ra2) ? i_wd : regs_q[i_ra2];
endmodule

// File: rtl/if_id_decode.sv
// if_id_decode: IF/ID latch with stall/flush, field decode, register read and sign extension
//  clk, rst (async active-low); i_IF {PC+4, instr}; i_IF_ID_write stall control; i_flush squash;
//  i_RegWrite/i_write_reg/i_write_data WB port; outputs: latched pc/instr/valid, fields, reads, imm
module if_id_decode
   import if_id_decode_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [2*DATA_W-1:0]   i_IF,
   input  logic                  i_IF_ID_write,
   input  logic                  i_flush,
   input  logic                  i_RegWrite,
   input  logic [REG_ADDR_W-1:0] i_write_reg,
   input  logic [DATA_W-1:0]     i_write_data,
   output logic [DATA_W-1:0]     o_pc_plus4,
   output logic [DATA_W-1:0]     o_instr,
   output logic                  o_valid,
   output logic [OPCODE_W-1:0]   o_opcode,
   output logic [FUNCT_W-1:0]    o_funct,
   output logic [REG_ADDR_W-1:0] o_rs,
   output logic [REG_ADDR_W-1:0] o_rt,
   output logic [REG_ADDR_W-1:0] o_rd,
   output logic [DATA_W-1:0]     o_read_data_1,
   output logic [DATA_W-1:0]     o_read_data_2,
   output logic [DATA_W-1:0]     o_sign_ext
);
   logic [DATA_W-1:0] pc_q, pc_d, instr_q, instr_d;
   logic              valid_q, valid_d;

   // Flush beats stall: a squashed slot must not survive a held latch
   always_comb begin
      pc_d    = i_flush ? '0 : i_IF_ID_write ? i_IF[2*DATA_W-1:DATA_W] : pc_q;
      instr_d = i_flush ? NOP_INSTR : i_IF_ID_write ? i_IF[DATA_W-1:0] : instr_q;
      valid_d = i_flush ? 1'b0 : i_IF_ID_write ? 1'b1 : valid_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q    <= '0;
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   assign o_pc_plus4 = pc_q;
   assign o_instr    = instr_q;
   assign o_valid    = valid_q;
   assign o_opcode   = instr_q[OPCODE_LSB +: OPCODE_W];
   assign o_funct    = instr_q[FUNCT_W-1:0];
   assign o_rs       = instr_q[RS_LSB +: REG_ADDR_W];
   assign o_rt       = instr_q[RT_LSB +: REG_ADDR_W];
   assign o_rd       = instr_q[RD_LSB +: REG_ADDR_W];
   assign o_sign_ext = sign_ext16(instr_q[15:0]);

   register_file u_rf (
      .clk   (clk),
      .rst   (rst),
      .i_we  (i_RegWrite),
      .i_wa  (i_write_reg),
      .i_wd  (i_write_data),
      .i_ra1 (o_rs),
      .i_ra2 (o_rt),
      .o_rd1 (o_read_data_1),
      .o_rd2 (o_read_data_2)
   );
endmodule
